// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and a one-cycle tc pulse.
// Optional prescaler enabled by defining DOWN_COUNTER_PRESCALE_EN (adds the prescale port).
module down_counter_timer #(
  parameter int WIDTH      = 51,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             en,
  input  logic             abort,
`ifdef DOWN_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_n;
  logic [WIDTH-1:0]      count_n, reload, reload_n;
  logic                  tc_n, mode, mode_n, tick;
  logic [PRESCALE_W-1:0] pre_cnt, pre_cnt_n, pre_val, pre_val_n, prescale_in;

  // Without the prescaler the divider is tied to 0, so every enabled cycle is a tick.
`ifdef DOWN_COUNTER_PRESCALE_EN
  assign prescale_in = prescale;
`else
  assign prescale_in = '0;
`endif

  assign load_ready = (state != RUN) && !abort;
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      tc      <= 1'b0;
      reload  <= '0;
      mode    <= 1'b0;
      pre_cnt <= '0;
      pre_val <= '0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      tc      <= tc_n;
      reload  <= reload_n;
      mode    <= mode_n;
      pre_cnt <= pre_cnt_n;
      pre_val <= pre_val_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    tc_n      = 1'b0;
    reload_n  = reload;
    mode_n    = mode;
    pre_cnt_n = pre_cnt;
    pre_val_n = pre_val;
    tick      = (pre_cnt == pre_val);
    if (abort) begin
      state_n   = IDLE;
      count_n   = '0;
      pre_cnt_n = '0;
    end else if (load_valid && load_ready) begin
      pre_cnt_n = '0;
      pre_val_n = prescale_in;
      if (load_value != '0) begin
        state_n  = RUN;
        count_n  = load_value;
        reload_n = load_value;
        mode_n   = auto_reload;
      end else begin
        // Zero load expires immediately as a one-shot.
        state_n = DONE;
        count_n = '0;
        tc_n    = 1'b1;
      end
    end else if (state == RUN && en) begin
      if (!tick) begin
        pre_cnt_n = pre_cnt + PRESCALE_W'(1);
      end else begin
        pre_cnt_n = '0;
        if (count > WIDTH'(1)) begin
          count_n = count - WIDTH'(1);
        end else begin
          // count==1 in RUN: terminal count, reload or finish.
          tc_n = 1'b1;
          if (mode) begin
            count_n = reload;
          end else begin
            count_n = '0;
            state_n = DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer with hand-computed expectations.
// Prescale vector runs only when DOWN_COUNTER_PRESCALE_EN is defined.
module tb_down_counter_timer;

  localparam int WIDTH = 51;

  logic             clk = 1'b0;
  logic             rst, load_valid, load_ready, auto_reload, en, abort;
  logic [WIDTH-1:0] load_value, count;
  logic             busy, tc, done;
  logic [7:0]       prescale;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(WIDTH), .PRESCALE_W(8)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_value(load_value),
    .auto_reload(auto_reload), .en(en), .abort(abort),
`ifdef DOWN_COUNTER_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(count), .busy(busy), .tc(tc), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a load for one edge, then withdraw it.
  task automatic load(input logic [WIDTH-1:0] v, input logic ar);
    load_valid  = 1'b1;
    load_value  = v;
    auto_reload = ar;
    step();
    load_valid  = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] e, prev;
    rst = 1'b1; load_valid = 1'b0; load_value = '0; auto_reload = 1'b0;
    en = 1'b1; abort = 1'b0; prescale = '0;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", load_ready, 1);
    rst = 1'b0;

    // Reset mid-run at count=7
    load(10, 1'b0);
    chk("run_first", count, 10);
    step(); step(); step();
    chk("run_at7", count, 7);
    rst = 1'b1;
    step(); step();
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tc", tc, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", load_ready, 1);
    rst = 1'b0;

    // One-shot V=5
    load(5, 1'b0);
    chk("os_count5", count, 5);
    chk("os_busy", busy, 1);
    chk("os_tc5", tc, 0);
    for (int i = 4; i >= 0; i--) begin
      step();
      chk("os_count", count, i);
      chk("os_tc", tc, (i == 0));
    end
    chk("os_done", done, 1);
    chk("os_busy_end", busy, 0);
    chk("os_ready_end", load_ready, 1);
    step();
    chk("os_tc_after", tc, 0);
    chk("os_hold0", count, 0);

    // Auto-reload V=3, with a load offered mid-run that must be ignored
    load(3, 1'b1);
    e = 3;
    chk("ar_count3", count, 3);
    for (int i = 0; i < 10; i++) begin
      chk("ar_ready", load_ready, 0);
      chk("ar_busy", busy, 1);
      if (i == 4) begin load_valid = 1'b1; load_value = 9; end
      prev = e;
      e = (e == 1) ? 3 : e - 1;
      step();
      load_valid = 1'b0;
      chk("ar_count", count, e);
      chk("ar_tc", tc, (prev == 1));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ar_abort_cnt", count, 0);
    chk("ar_abort_busy", busy, 0);

    // Auto-reload V=1: tc every enabled cycle
    load(1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar1_count", count, 1);
      chk("ar1_tc", tc, 1);
    end
    abort = 1'b1; step(); abort = 1'b0;

    // Pause at count=2
    load(4, 1'b0);
    step(); step();
    chk("pz_count2", count, 2);
    en = 1'b0;
    step();
    chk("pz_hold1", count, 2);
    chk("pz_tc_hold", tc, 0);
    step();
    chk("pz_hold2", count, 2);
    en = 1'b1;
    step();
    chk("pz_count1", count, 1);
    chk("pz_tc_early", tc, 0);
    step();
    chk("pz_count0", count, 0);
    chk("pz_tc", tc, 1);

    // Abort colliding with a load at count=2
    load(4, 1'b0);
    step(); step();
    chk("ab_count2", count, 2);
    abort = 1'b1; load_valid = 1'b1; load_value = 9;
    #1;
    chk("ab_ready", load_ready, 0);
    step();
    abort = 1'b0; load_valid = 1'b0;
    chk("ab_count", count, 0);
    chk("ab_busy", busy, 0);
    chk("ab_tc", tc, 0);
    chk("ab_done", done, 0);
    load(0, 1'b1);
    chk("z_tc", tc, 1);
    chk("z_done", done, 1);
    chk("z_count", count, 0);
    step();
    chk("z_tc_off", tc, 0);

    // Abort at count=1 suppresses the pending terminal count
    load(2, 1'b0);
    step();
    chk("abp_count1", count, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abp_tc", tc, 0);
    chk("abp_done", done, 0);

    // Width boundary
    load({WIDTH{1'b1}}, 1'b0);
    step(); step(); step();
    chk("wb_count", count, {WIDTH{1'b1}} - 51'd3);
    chk("wb_tc", tc, 0);
    abort = 1'b1; step(); abort = 1'b0;

`ifdef DOWN_COUNTER_PRESCALE_EN
    prescale = 8'd3;
    load(2, 1'b0);
    prescale = '0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("ps_tc", tc, (i == 8));
      if (i == 4) chk("ps_count", count, 1);
    end
    chk("ps_done", done, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down-counting timer, the count-down counterpart of the team's free-running 51-bit up counter. A host loads a start value through a valid/ready handshake. The block decrements once per enabled cycle and pulses a terminal-count flag on reaching zero. It supports one-shot and auto-reload (periodic tick) modes and sits beside the up counter as the timeout/period generator.

Parameters:
WIDTH, 51, counter and load-value width in bits
PRESCALE_W, 8, prescale divider width (used only when DOWN_COUNTER_PRESCALE_EN is defined)

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  synchronous, active-high reset
load_valid  input  1  host offers load_value
load_ready  output  1  block can accept a load this cycle
load_value  input  WIDTH  start/reload value V
auto_reload  input  1  mode select, sampled only at load acceptance: 1 = periodic, 0 = one-shot
en  input  1  count enable; 0 pauses in RUN
abort  input  1  cancel any operation; highest priority
count  output  WIDTH  current counter value (registered)
busy  output  1  high while in RUN
tc  output  1  registered one-cycle terminal-count pulse
done  output  1  high while in DONE (one-shot finished)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, count=0, tc=0, busy=0, done=0, stored reload=0, stored mode=0. Reset dominates abort, load and counting, including mid-run.
- States are IDLE, RUN and DONE. busy=(state==RUN). done=(state==DONE).
- load_ready is combinational: load_ready = (state!=RUN) && !abort. A load is accepted when load_valid && load_ready at a posedge. Loads offered during RUN are ignored, not queued.
- Accept with V!=0: next cycle count=V, state=RUN, stored reload=V, stored mode=auto_reload, done=0.
- Accept with V==0: next cycle count=0, tc=1, state=DONE (one-shot, regardless of auto_reload).
- RUN, en=1, count>1: count decrements by 1.
- RUN, en=1, count==1, stored mode=0: count becomes 0, tc=1, state=DONE.
- RUN, en=1, count==1, stored mode=1: count becomes the stored reload, tc=1, state stays RUN. This gives a period of exactly V enabled cycles. With V=1, tc is high on every enabled cycle and count stays 1.
- RUN, en=0: count, state and prescaler are held; tc=0.
- tc is 0 in every cycle other than those listed above.
- Count never underflows; no wrap below 0.
- Arithmetic is unsigned WIDTH-bit. The full range up to 2^WIDTH-1 is valid.
- abort=1 (rst=0): next cycle state=IDLE, count=0, tc=0, done=0. No load is accepted that cycle and any pending terminal count is suppressed.
- DONE: count holds 0 and load_ready=1. A new load leaves DONE exactly as from IDLE.
- Latency: load acceptance to first count update is 1 cycle. With a constant en=1, load of V to tc pulse is V cycles after count first shows V.

Optional Feature:
Macro: DOWN_COUNTER_PRESCALE_EN.
- Defined: adds input port prescale [PRESCALE_W-1:0], sampled at load acceptance. In RUN, count decrements once every prescale+1 enabled cycles, with tc aligned to the decrement that reaches 0 or reloads. The prescaler is cleared on load, abort, reset and auto-reload; en=0 holds it. prescale=0 behaves identically to the macro being undefined.
- Undefined: no prescale port; count decrements on every enabled cycle.

Test Plan:
1. Reset check: assert rst 2 cycles mid-run at count=7 -> count=0, busy=0, tc=0, done=0, load_ready=1.
2. One-shot: load V=5, auto_reload=0, en=1 -> count 5,4,3,2,1,0; tc high only in the cycle count=0; done=1; busy=0; load_ready=1.
3. Auto-reload: load V=3, auto_reload=1, en=1 for 10 cycles -> count 3,2,1,3,2,1,3,...; tc every 3rd cycle; load_ready=0 and busy=1 throughout.
4. Pause: load V=4, drop en for 2 cycles when count=2 -> count holds 2 for those cycles; tc arrives 2 cycles later than in the unpaused case.
5. Abort collision: at count=2 assert abort with load_valid=1, load_value=9 -> next cycle state=IDLE, count=0, no tc, load not accepted. Load V=0 from IDLE -> tc next cycle, done=1.
6. Width boundary: load V=2^51-1, en=1 for 3 cycles -> count=2^51-4, no tc. With the macro defined, load V=2 and prescale=3 -> tc on the 8th enabled cycle after load.
